// File: rtl/id_ex_stage_fwd_pkg.sv
// Shared core definitions for the ID/EX stage: widths, bubble word,
// control-bundle layout and forwarding-source codes.
package core_pkg;
    localparam int          XLEN      = 32;
    localparam int          REG_IDX_W = 5;
    localparam int          CTRL_W    = 16;
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

    // Bit offsets of the fields packed into the control bundle
    localparam int CTRL_MEM_READ  = 0;
    localparam int CTRL_MEM_WRITE = 1;
    localparam int CTRL_REG_WRITE = 2;
    localparam int CTRL_ALU_SRC   = 3;
    localparam int CTRL_BRANCH    = 4;
    localparam int CTRL_JUMP      = 5;
    localparam int CTRL_ALU_OP_LSB = 6;
    localparam int CTRL_ALU_OP_W   = 4;
    localparam int CTRL_WB_SEL_LSB = 10;
    localparam int CTRL_WB_SEL_W   = 2;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2,
        FWD_WB    = 2'd3
    } fwd_src_e;

    // Source index to reported code; indices past the third share the top code.
    function automatic fwd_src_e fwd_code(input int idx);
        logic [1:0] c;
        if (idx >= 2) c = 2'd3;
        else          c = 2'(idx + 1);
        return fwd_src_e'(c);
    endfunction
endpackage

// File: rtl/id_ex_stage_fwd_if.sv
// ID/EX boundary bundle: ID-side inputs, forwarding sources and registered EX-side outputs.
interface id_ex_stage_fwd_if #(
    parameter int XLEN    = 32,
    parameter int CTRL_W  = 16,
    parameter int NUM_FWD = 3
);
    import core_pkg::*;

    logic                          stall;
    logic                          flush;
    logic                          in_valid;
    logic [CTRL_W-1:0]             in_ctrl;
    logic [XLEN-1:0]               in_pc;
    logic [XLEN-1:0]               in_pc4;
    logic [XLEN-1:0]               in_imm;
    logic [31:0]                   in_inst;
    logic [REG_IDX_W-1:0]          in_rs1_addr;
    logic [REG_IDX_W-1:0]          in_rs2_addr;
    logic [XLEN-1:0]               in_rs1_data;
    logic [XLEN-1:0]               in_rs2_data;
    logic [NUM_FWD-1:0]            fwd_valid;
    logic [REG_IDX_W*NUM_FWD-1:0]  fwd_rd;
    logic [XLEN*NUM_FWD-1:0]       fwd_data;

    logic                          out_valid;
    logic [CTRL_W-1:0]             out_ctrl;
    logic [XLEN-1:0]               out_pc;
    logic [XLEN-1:0]               out_pc4;
    logic [XLEN-1:0]               out_imm;
    logic [31:0]                   out_inst;
    logic [REG_IDX_W-1:0]          out_rs1_addr;
    logic [REG_IDX_W-1:0]          out_rs2_addr;
    logic [XLEN-1:0]               out_rs1;
    logic [XLEN-1:0]               out_rs2;
    logic [1:0]                    out_fwd1;
    logic [1:0]                    out_fwd2;

    modport master (
        output stall, flush, in_valid, in_ctrl, in_pc, in_pc4, in_imm, in_inst,
               in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
               fwd_valid, fwd_rd, fwd_data,
        input  out_valid, out_ctrl, out_pc, out_pc4, out_imm, out_inst,
               out_rs1_addr, out_rs2_addr, out_rs1, out_rs2, out_fwd1, out_fwd2
    );

    modport slave (
        input  stall, flush, in_valid, in_ctrl, in_pc, in_pc4, in_imm, in_inst,
               in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
               fwd_valid, fwd_rd, fwd_data,
        output out_valid, out_ctrl, out_pc, out_pc4, out_imm, out_inst,
               out_rs1_addr, out_rs2_addr, out_rs1, out_rs2, out_fwd1, out_fwd2
    );
endinterface

// File: rtl/id_ex_stage_fwd_fwd_select.sv
// Combinational priority matcher: the lowest-index valid source writing a
// non-zero register equal to addr supplies the data, otherwise dflt passes through.
module fwd_select
    import core_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 3
) (
    input  logic [REG_IDX_W-1:0]         addr,
    input  logic [XLEN-1:0]              dflt,
    input  logic [NUM_FWD-1:0]           src_valid,
    input  logic [REG_IDX_W*NUM_FWD-1:0] src_rd,
    input  logic [XLEN*NUM_FWD-1:0]      src_data,
    output logic [XLEN-1:0]              data,
    output logic                         hit,
    output fwd_src_e                     code
);
    always_comb begin
        data = dflt;
        hit  = 1'b0;
        code = FWD_RF;
        // Walk from oldest to youngest so the lowest index overwrites last.
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (src_valid[i] && (src_rd[i*REG_IDX_W +: REG_IDX_W] == addr) && (addr != '0)) begin
                data = src_data[i*XLEN +: XLEN];
                hit  = 1'b1;
                code = fwd_code(i);
            end
        end
    end
endmodule

// File: rtl/id_ex_stage_fwd.sv
// ID/EX pipeline register with stall hold, flush bubble and priority operand
// forwarding that keeps refreshing held operands. Optional counters: ID_EX_PERF_EN.
module id_ex_stage_fwd
    import core_pkg::*;
#(
    parameter int          XLEN     = core_pkg::XLEN,
    parameter int          CTRL_W   = core_pkg::CTRL_W,
    parameter int          NUM_FWD  = 3,
    parameter logic [31:0] NOP_INST = core_pkg::NOP_INST
) (
    input  logic                clk,
    input  logic                reset,
`ifdef ID_EX_PERF_EN
    output logic [31:0]         perf_bubbles,
    output logic [31:0]         perf_stalls,
    output logic [31:0]         perf_fwd_hits,
`endif
    id_ex_stage_fwd_if.slave    bus
);
    logic                 valid_q, valid_d;
    logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
    logic [XLEN-1:0]      pc_q, pc_d, pc4_q, pc4_d, imm_q, imm_d;
    logic [31:0]          inst_q, inst_d;
    logic [REG_IDX_W-1:0] rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d;
    logic [XLEN-1:0]      rs1_q, rs1_d, rs2_q, rs2_d;
    logic [1:0]           fwd1_q, fwd1_d, fwd2_q, fwd2_d;

    logic                 hold_ops;
    logic [REG_IDX_W-1:0] sel1_addr, sel2_addr;
    logic [XLEN-1:0]      sel1_dflt, sel2_dflt, sel1_data, sel2_data;
    logic                 hit1, hit2;
    fwd_src_e             code1, code2;

    // While stalled the matchers look at the held operands instead of ID.
    assign hold_ops  = bus.stall && !bus.flush;
    assign sel1_addr = hold_ops ? rs1_addr_q : bus.in_rs1_addr;
    assign sel2_addr = hold_ops ? rs2_addr_q : bus.in_rs2_addr;
    assign sel1_dflt = hold_ops ? rs1_q      : bus.in_rs1_data;
    assign sel2_dflt = hold_ops ? rs2_q      : bus.in_rs2_data;

    fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_sel1 (
        .addr(sel1_addr), .dflt(sel1_dflt), .src_valid(bus.fwd_valid),
        .src_rd(bus.fwd_rd), .src_data(bus.fwd_data),
        .data(sel1_data), .hit(hit1), .code(code1)
    );

    fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_sel2 (
        .addr(sel2_addr), .dflt(sel2_dflt), .src_valid(bus.fwd_valid),
        .src_rd(bus.fwd_rd), .src_data(bus.fwd_data),
        .data(sel2_data), .hit(hit2), .code(code2)
    );

    always_comb begin
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        pc_d       = pc_q;
        pc4_d      = pc4_q;
        imm_d      = imm_q;
        inst_d     = inst_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        fwd1_d     = fwd1_q;
        fwd2_d     = fwd2_q;
        if (bus.flush) begin
            // Bubble; pc/imm/operands still load raw so a debugger can see what was squashed.
            valid_d    = 1'b0;
            ctrl_d     = '0;
            inst_d     = NOP_INST;
            rs1_addr_d = '0;
            rs2_addr_d = '0;
            fwd1_d     = 2'd0;
            fwd2_d     = 2'd0;
            pc_d       = bus.in_pc;
            pc4_d      = bus.in_pc4;
            imm_d      = bus.in_imm;
            rs1_d      = bus.in_rs1_data;
            rs2_d      = bus.in_rs2_data;
        end else if (!bus.stall) begin
            valid_d    = bus.in_valid;
            ctrl_d     = bus.in_ctrl;
            pc_d       = bus.in_pc;
            pc4_d      = bus.in_pc4;
            imm_d      = bus.in_imm;
            inst_d     = bus.in_inst;
            rs1_addr_d = bus.in_rs1_addr;
            rs2_addr_d = bus.in_rs2_addr;
            rs1_d      = sel1_data;
            rs2_d      = sel2_data;
            fwd1_d     = code1;
            fwd2_d     = code2;
        end else begin
            rs1_d = sel1_data;
            rs2_d = sel2_data;
            if (hit1) fwd1_d = code1;
            if (hit2) fwd2_d = code2;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            pc_q       <= '0;
            pc4_q      <= '0;
            imm_q      <= '0;
            inst_q     <= NOP_INST;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            fwd1_q     <= 2'd0;
            fwd2_q     <= 2'd0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            pc4_q      <= pc4_d;
            imm_q      <= imm_d;
            inst_q     <= inst_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            fwd1_q     <= fwd1_d;
            fwd2_q     <= fwd2_d;
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_ctrl     = ctrl_q;
    assign bus.out_pc       = pc_q;
    assign bus.out_pc4      = pc4_q;
    assign bus.out_imm      = imm_q;
    assign bus.out_inst     = inst_q;
    assign bus.out_rs1_addr = rs1_addr_q;
    assign bus.out_rs2_addr = rs2_addr_q;
    assign bus.out_rs1      = rs1_q;
    assign bus.out_rs2      = rs2_q;
    assign bus.out_fwd1     = fwd1_q;
    assign bus.out_fwd2     = fwd2_q;

`ifdef ID_EX_PERF_EN
    logic [31:0] perf_bubbles_q, perf_bubbles_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;
    logic [31:0] perf_fwd_hits_q, perf_fwd_hits_d;

    always_comb begin
        perf_bubbles_d  = perf_bubbles_q;
        perf_stalls_d   = perf_stalls_q;
        perf_fwd_hits_d = perf_fwd_hits_q;
        if (bus.flush) begin
            perf_bubbles_d = perf_bubbles_q + 32'd1;
        end else begin
            if (bus.stall) perf_stalls_d = perf_stalls_q + 32'd1;
            perf_fwd_hits_d = perf_fwd_hits_q + {31'd0, hit1} + {31'd0, hit2};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_bubbles_q  <= '0;
            perf_stalls_q   <= '0;
            perf_fwd_hits_q <= '0;
        end else begin
            perf_bubbles_q  <= perf_bubbles_d;
            perf_stalls_q   <= perf_stalls_d;
            perf_fwd_hits_q <= perf_fwd_hits_d;
        end
    end

    assign perf_bubbles  = perf_bubbles_q;
    assign perf_stalls   = perf_stalls_q;
    assign perf_fwd_hits = perf_fwd_hits_q;
`endif
endmodule

// File: doc/id_ex_stage_fwd.md
Name: id_ex_stage_fwd

Overview:
- Parametrised ID/EX pipeline register for the pipelined RV32I core.
- Captures decoded instruction fields and control bits at the ID/EX boundary.
- Supports hold on stall and bubble insertion on flush.
- Resolves operand hazards with an N-source priority forwarding network.
- Keeps held operands coherent while stalled; the single-cycle hazard logic did not.
- Feeds the EX stage: ALU operand muxes and branch compare.

Parameters:
- XLEN, 32, datapath width for pc, operands and immediate.
- CTRL_W, 16, width of the packed control bundle (mem_read, mem_write, alu_op, jump, ...).
- NUM_FWD, 3, forwarding sources. Index 0 is the youngest/highest priority (EX/MEM ALU), then MEM/WB load data, then WB.
- NOP_INST, 32'h00000013, instruction word inserted on a bubble.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low.
- stall  in  1  hold current contents.
- flush  in  1  insert bubble (branch/jump taken).
- in_valid  in  1  ID stage holds a real instruction.
- in_ctrl  in  CTRL_W  decoded control bundle.
- in_pc, in_pc4, in_imm  in  XLEN  pc, pc+4, sign-extended immediate.
- in_inst  in  32  raw instruction.
- in_rs1_addr, in_rs2_addr  in  5  source register indices.
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data.
- fwd_valid  in  NUM_FWD  source i carries a pending write.
- fwd_rd  in  5*NUM_FWD  destination index per source.
- fwd_data  in  XLEN*NUM_FWD  result per source.
- out_valid  out  1  registered valid.
- out_ctrl  out  CTRL_W  registered control.
- out_pc, out_pc4, out_imm  out  XLEN  registered fields.
- out_inst  out  32  registered instruction.
- out_rs1_addr, out_rs2_addr  out  5  registered indices.
- out_rs1, out_rs2  out  XLEN  forwarded operands.
- out_fwd1, out_fwd2  out  2  last capture source per operand: 0 = regfile, i+1 = fwd source i. Saturates at 3.

Behaviour:
- All state updates on posedge clk. Priority: reset > flush > stall > load.
- Reset (reset==0), including mid-stall or mid-flush:
  - out_valid=0, out_ctrl=0, out_inst=NOP_INST.
  - All other outputs 0.
- Flush:
  - out_valid=0, out_ctrl=0, out_inst=NOP_INST, out_rs1_addr=out_rs2_addr=0, out_fwd*=0.
  - pc, pc4, imm and operands load from in_* (debug visibility only).
  - Flush with stall asserted: flush wins.
- Load (no stall, no flush):
  - All fields take in_*; out_valid=in_valid.
  - out_rs1 = forward(in_rs1_addr, in_rs1_data). out_rs2 likewise.
- forward(a, d):
  - Select the lowest i with fwd_valid[i] && fwd_rd[i]==a && a!=0; return fwd_data[i].
  - If no source matches, return d.
  - Index x0 never forwards.
- Stall:
  - Control, pc, inst, imm, addresses and valid hold.
  - Operands refresh: out_rs1 = forward(out_rs1_addr, out_rs1); out_rs2 likewise.
  - out_fwd* updates only when a source hits.
  - This lets a producer that retires during a multi-cycle stall still reach the held consumer.
- Latency: one cycle from in_* to out_*. Forwarding is combinational into the capture flops, so there is no extra stage.
- Both operands may hit the same source; each resolves independently.
- Several sources may match the same index: the lowest index wins. The youngest producer is the architecturally correct value.

Optional Feature:
- ID_EX_PERF_EN defined adds three 32-bit wrapping counters, cleared on reset:
  - perf_bubbles (flush cycles).
  - perf_stalls (stall cycles with no flush).
  - perf_fwd_hits (+1 per operand captured from a source, so up to +2 per cycle).
- These are exposed on extra outputs perf_bubbles, perf_stalls, perf_fwd_hits.
- Undefined: no counters and no ports.

Decomposition:
- Shared package core_pkg: XLEN, REG_IDX_W=5, NOP_INST, control-bundle field offsets, forwarding-source enum (FWD_RF, FWD_EXMEM, FWD_MEMWB, FWD_WB).
- One sub-module, fwd_select: parametrised combinational priority matcher (addr, default data, sources -> data, source code). Instantiated twice.

Test Plan:
- Reset: hold reset=0 with in_valid=1, stall=1 for 2 cycles -> out_valid=0, out_inst=32'h13, out_rs1=0.
- Plain load: rs1_addr=5, rs1_data=0xA, no fwd_valid -> next cycle out_rs1=0xA, out_fwd1=0.
- Priority: fwd0 rd=5 data=0x111 and fwd1 rd=5 data=0x222, load rs1_addr=5 -> out_rs1=0x111, out_fwd1=1. With fwd0 dropped -> out_rs1=0x222, out_fwd1=2.
- x0 guard: fwd0 rd=0 data=0xDEAD, rs2_addr=0, rs2_data=0 -> out_rs2=0.
- Stall refresh: load rs1_addr=7 (no hit, value 0x1), stall 3 cycles, pulse fwd2 rd=7 data=0x77 in cycle 2 -> out_rs1=0x77 from cycle 3; pc/inst unchanged throughout.
- Flush over stall: stall=1 and flush=1 together -> out_valid=0, out_ctrl=0, out_inst=0x13. With ID_EX_PERF_EN, perf_bubbles increments and perf_stalls does not.
